// File: rtl/axil_decoder_nxm.sv
// axil_decoder_nxm: AXI4-Lite 1-to-N address decoder.
// One upstream port s0 fanned out by address region to NUM_SLAVES ports m.
// Ports:
//   s0_axi_aclk/aresetn  clock, async active-low reset
//   s0_axi_aw*/w*/b*     upstream write address/data/response
//   s0_axi_ar*/r*        upstream read address/data
//   m_axi_*              downstream ports, packed; slice i = port i
// Unmapped regions answer locally with DECERR. All outputs registered.
module axil_decoder_nxm #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int RESP_WIDTH  = 2,
  parameter int NUM_SLAVES  = 2,
  parameter int REGION_BITS = 4
) (
  input  logic                             s0_axi_aclk,
  input  logic                             s0_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]            s0_axi_awaddr,
  input  logic                             s0_axi_awvalid,
  output logic                             s0_axi_awready,
  input  logic [DATA_WIDTH-1:0]            s0_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]          s0_axi_wstrb,
  input  logic                             s0_axi_wvalid,
  output logic                             s0_axi_wready,
  output logic [RESP_WIDTH-1:0]            s0_axi_bresp,
  output logic                             s0_axi_bvalid,
  input  logic                             s0_axi_bready,
  input  logic [ADDR_WIDTH-1:0]            s0_axi_araddr,
  input  logic                             s0_axi_arvalid,
  output logic                             s0_axi_arready,
  output logic [DATA_WIDTH-1:0]            s0_axi_rdata,
  output logic [RESP_WIDTH-1:0]            s0_axi_rresp,
  output logic                             s0_axi_rvalid,
  input  logic                             s0_axi_rready,
  output logic [NUM_SLAVES*ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [NUM_SLAVES-1:0]            m_axi_awvalid,
  input  logic [NUM_SLAVES-1:0]            m_axi_awready,
  output logic [NUM_SLAVES*DATA_WIDTH-1:0] m_axi_wdata,
  output logic [NUM_SLAVES*DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic [NUM_SLAVES-1:0]            m_axi_wvalid,
  input  logic [NUM_SLAVES-1:0]            m_axi_wready,
  input  logic [NUM_SLAVES*RESP_WIDTH-1:0] m_axi_bresp,
  input  logic [NUM_SLAVES-1:0]            m_axi_bvalid,
  output logic [NUM_SLAVES-1:0]            m_axi_bready,
  output logic [NUM_SLAVES*ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [NUM_SLAVES-1:0]            m_axi_arvalid,
  input  logic [NUM_SLAVES-1:0]            m_axi_arready,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [NUM_SLAVES*RESP_WIDTH-1:0] m_axi_rresp,
  input  logic [NUM_SLAVES-1:0]            m_axi_rvalid,
  output logic [NUM_SLAVES-1:0]            m_axi_rready
);

  localparam int NS = NUM_SLAVES;
  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int RW = RESP_WIDTH;
  localparam int SW = DATA_WIDTH / 8;
  localparam int IW = ADDR_WIDTH - REGION_BITS;
  localparam logic [RW-1:0] DECERR = RW'(3);

  typedef enum logic [1:0] {
    W_IDLE, W_FWD, W_BWAIT, W_RESP
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE, R_FWD, R_DWAIT, R_RESP
  } r_state_t;

  typedef struct packed {
    w_state_t         st;
    logic             aw_held;
    logic             w_held;
    logic [AW-1:0]    addr;
    logic [DW-1:0]    data;
    logic [SW-1:0]    strb;
    logic [NS-1:0]    sel;
    logic             awready;
    logic             wready;
    logic [NS-1:0]    awvalid;
    logic [NS-1:0]    wvalid;
    logic [NS-1:0]    bready;
    logic [NS*AW-1:0] m_addr;
    logic [NS*DW-1:0] m_data;
    logic [NS*SW-1:0] m_strb;
    logic             bvalid;
    logic [RW-1:0]    bresp;
  } wr_t;

  typedef struct packed {
    r_state_t         st;
    logic [NS-1:0]    sel;
    logic             arready;
    logic [NS-1:0]    arvalid;
    logic [NS-1:0]    rready;
    logic [NS*AW-1:0] m_addr;
    logic             rvalid;
    logic [DW-1:0]    rdata;
    logic [RW-1:0]    rresp;
  } rd_t;

  // One-hot port select; all-zero means the address is unmapped.
  function automatic logic [NS-1:0] decode(
    input logic [AW-1:0] a
  );
    logic [IW-1:0] idx;
    logic [NS-1:0] oh;
    idx = a[AW-1:REGION_BITS];
    oh  = '0;
    for (int i = 0; i < NS; i++)
      oh[i] = (idx == IW'(i));
    return oh;
  endfunction

  function automatic logic [RW-1:0] pick_resp(
    input logic [NS*RW-1:0] bus,
    input logic [NS-1:0]    sel
  );
    logic [RW-1:0] r;
    r = '0;
    for (int i = 0; i < NS; i++)
      if (sel[i]) r = r | bus[i*RW +: RW];
    return r;
  endfunction

  function automatic logic [DW-1:0] pick_data(
    input logic [NS*DW-1:0] bus,
    input logic [NS-1:0]    sel
  );
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < NS; i++)
      if (sel[i]) r = r | bus[i*DW +: DW];
    return r;
  endfunction

  wr_t wq, wn;
  rd_t rq, rn;
  logic [NS-1:0] w_hit, r_hit;
  logic aw_fin, w_fin;

  // A downstream channel is finished once its valid has been accepted.
  assign aw_fin = ~|wq.awvalid
                | |(wq.awvalid & m_axi_awready);
  assign w_fin  = ~|wq.wvalid
                | |(wq.wvalid & m_axi_wready);

  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) begin
      wq <= '0;
      rq <= '0;
    end else begin
      wq <= wn;
      rq <= rn;
    end
  end

  always_comb begin
    wn    = wq;
    w_hit = '0;
    unique case (wq.st)
      W_IDLE: begin
        if (wq.awready && s0_axi_awvalid) begin
          wn.aw_held = 1'b1;
          wn.addr    = s0_axi_awaddr;
        end
        if (wq.wready && s0_axi_wvalid) begin
          wn.w_held = 1'b1;
          wn.data   = s0_axi_wdata;
          wn.strb   = s0_axi_wstrb;
        end
        wn.awready = !wn.aw_held;
        wn.wready  = !wn.w_held;
        // Decide on the capturing edge so a miss answers one edge later.
        if (wn.aw_held && wn.w_held) begin
          w_hit      = decode(wn.addr);
          wn.aw_held = 1'b0;
          wn.w_held  = 1'b0;
          wn.awready = 1'b0;
          wn.wready  = 1'b0;
          wn.sel     = w_hit;
          if (|w_hit) begin
            wn.st      = W_FWD;
            wn.awvalid = w_hit;
            wn.wvalid  = w_hit;
            for (int i = 0; i < NS; i++) begin
              wn.m_addr[i*AW +: AW] = w_hit[i] ? wn.addr : '0;
              wn.m_data[i*DW +: DW] = w_hit[i] ? wn.data : '0;
              wn.m_strb[i*SW +: SW] = w_hit[i] ? wn.strb : '0;
            end
          end else begin
            wn.st     = W_RESP;
            wn.bvalid = 1'b1;
            wn.bresp  = DECERR;
          end
        end
      end
      W_FWD: begin
        if (aw_fin) wn.awvalid = '0;
        if (w_fin)  wn.wvalid  = '0;
        if (aw_fin && w_fin) begin
          wn.st     = W_BWAIT;
          wn.bready = wq.sel;
        end
      end
      W_BWAIT: begin
        if (|(m_axi_bvalid & wq.sel)) begin
          wn.bready = '0;
          wn.bvalid = 1'b1;
          wn.bresp  = pick_resp(m_axi_bresp, wq.sel);
          wn.st     = W_RESP;
        end
      end
      W_RESP: begin
        if (s0_axi_bready) begin
          wn.bvalid  = 1'b0;
          wn.awready = 1'b1;
          wn.wready  = 1'b1;
          wn.st      = W_IDLE;
        end
      end
      default: wn = '0;
    endcase
  end

  always_comb begin
    rn    = rq;
    r_hit = '0;
    unique case (rq.st)
      R_IDLE: begin
        rn.arready = 1'b1;
        if (rq.arready && s0_axi_arvalid) begin
          r_hit      = decode(s0_axi_araddr);
          rn.arready = 1'b0;
          rn.sel     = r_hit;
          if (|r_hit) begin
            rn.st      = R_FWD;
            rn.arvalid = r_hit;
            for (int i = 0; i < NS; i++)
              rn.m_addr[i*AW +: AW] =
                r_hit[i] ? s0_axi_araddr : '0;
          end else begin
            rn.st     = R_RESP;
            rn.rvalid = 1'b1;
            rn.rdata  = '0;
            rn.rresp  = DECERR;
          end
        end
      end
      R_FWD: begin
        if (|(rq.arvalid & m_axi_arready)) begin
          rn.arvalid = '0;
          rn.rready  = rq.sel;
          rn.st      = R_DWAIT;
        end
      end
      R_DWAIT: begin
        if (|(m_axi_rvalid & rq.sel)) begin
          rn.rready = '0;
          rn.rvalid = 1'b1;
          rn.rdata  = pick_data(m_axi_rdata, rq.sel);
          rn.rresp  = pick_resp(m_axi_rresp, rq.sel);
          rn.st     = R_RESP;
        end
      end
      R_RESP: begin
        if (s0_axi_rready) begin
          rn.rvalid  = 1'b0;
          rn.arready = 1'b1;
          rn.st      = R_IDLE;
        end
      end
      default: rn = '0;
    endcase
  end

  assign s0_axi_awready = wq.awready;
  assign s0_axi_wready  = wq.wready;
  assign s0_axi_bvalid  = wq.bvalid;
  assign s0_axi_bresp   = wq.bresp;
  assign m_axi_awaddr   = wq.m_addr;
  assign m_axi_awvalid  = wq.awvalid;
  assign m_axi_wdata    = wq.m_data;
  assign m_axi_wstrb    = wq.m_strb;
  assign m_axi_wvalid   = wq.wvalid;
  assign m_axi_bready   = wq.bready;

  assign s0_axi_arready = rq.arready;
  assign s0_axi_rvalid  = rq.rvalid;
  assign s0_axi_rdata   = rq.rdata;
  assign s0_axi_rresp   = rq.rresp;
  assign m_axi_araddr   = rq.m_addr;
  assign m_axi_arvalid  = rq.arvalid;
  assign m_axi_rready   = rq.rready;

endmodule

// File: tb/tb_axil_decoder_nxm.sv
// tb_axil_decoder_nxm: directed bench for axil_decoder_nxm.
// Two ports, 16-byte regions; stimulus and checks on the falling edge.
module tb_axil_decoder_nxm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_awaddr, s_araddr;
  logic        s_awvalid, s_awready;
  logic [31:0] s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid, s_wready;
  logic [1:0]  s_bresp, s_rresp;
  logic        s_bvalid, s_bready;
  logic        s_arvalid, s_arready;
  logic        s_rvalid, s_rready;
  logic [15:0] m_awaddr, m_araddr;
  logic [1:0]  m_awvalid, m_awready;
  logic [63:0] m_wdata, m_rdata;
  logic [7:0]  m_wstrb;
  logic [1:0]  m_wvalid, m_wready;
  logic [3:0]  m_bresp, m_rresp;
  logic [1:0]  m_bvalid, m_bready;
  logic [1:0]  m_arvalid, m_arready;
  logic [1:0]  m_rvalid, m_rready;

  int total = 0;
  int fails = 0;
  int cnt;

  always #5 clk = ~clk;

  axil_decoder_nxm dut (
    .s0_axi_aclk    (clk),
    .s0_axi_aresetn (rst_n),
    .s0_axi_awaddr  (s_awaddr),
    .s0_axi_awvalid (s_awvalid),
    .s0_axi_awready (s_awready),
    .s0_axi_wdata   (s_wdata),
    .s0_axi_wstrb   (s_wstrb),
    .s0_axi_wvalid  (s_wvalid),
    .s0_axi_wready  (s_wready),
    .s0_axi_bresp   (s_bresp),
    .s0_axi_bvalid  (s_bvalid),
    .s0_axi_bready  (s_bready),
    .s0_axi_araddr  (s_araddr),
    .s0_axi_arvalid (s_arvalid),
    .s0_axi_arready (s_arready),
    .s0_axi_rdata   (s_rdata),
    .s0_axi_rresp   (s_rresp),
    .s0_axi_rvalid  (s_rvalid),
    .s0_axi_rready  (s_rready),
    .m_axi_awaddr   (m_awaddr),
    .m_axi_awvalid  (m_awvalid),
    .m_axi_awready  (m_awready),
    .m_axi_wdata    (m_wdata),
    .m_axi_wstrb    (m_wstrb),
    .m_axi_wvalid   (m_wvalid),
    .m_axi_wready   (m_wready),
    .m_axi_bresp    (m_bresp),
    .m_axi_bvalid   (m_bvalid),
    .m_axi_bready   (m_bready),
    .m_axi_araddr   (m_araddr),
    .m_axi_arvalid  (m_arvalid),
    .m_axi_arready  (m_arready),
    .m_axi_rdata    (m_rdata),
    .m_axi_rresp    (m_rresp),
    .m_axi_rvalid   (m_rvalid),
    .m_axi_rready   (m_rready)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " s0"},
        {62'd0, s_bvalid, s_rvalid}, 64'd0);
    chk({tag, " mv"},
        {56'd0, m_awvalid, m_wvalid, m_arvalid,
         m_bready}, 64'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    s_awaddr  = '0; s_awvalid = 1'b0;
    s_wdata   = '0; s_wstrb   = '0;
    s_wvalid  = 1'b0; s_bready = 1'b0;
    s_araddr  = '0; s_arvalid = 1'b0;
    s_rready  = 1'b0;
    m_awready = 2'b11; m_wready = 2'b11;
    m_bvalid  = 2'b11; m_bresp  = 4'b0000;
    m_arready = 2'b11; m_rvalid = 2'b11;
    m_rdata   = '0;    m_rresp  = '0;

    // Reset state
    tick(); tick();
    chk("rst rdy", {61'd0, s_awready, s_wready,
                    s_arready}, 64'd0);
    chk_quiet("rst");
    chk("rst awaddr", {48'd0, m_awaddr}, 64'd0);
    chk("rst rdata", {32'd0, s_rdata}, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("idle rdy", {61'd0, s_awready, s_wready,
                     s_arready}, 64'd7);

    // 1: write 0x14, AW and W together
    s_awaddr = 8'h14; s_awvalid = 1'b1;
    s_wdata = 32'hDEADBEEF; s_wstrb = 4'hF;
    s_wvalid = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    chk("t1 awready", {63'd0, s_awready}, 64'd0);
    chk("t1 awvalid", {62'd0, m_awvalid}, 64'd2);
    chk("t1 wvalid", {62'd0, m_wvalid}, 64'd2);
    chk("t1 awaddr", {48'd0, m_awaddr}, 64'h1400);
    chk("t1 wdata", m_wdata, 64'hDEADBEEF_00000000);
    chk("t1 wstrb", {56'd0, m_wstrb}, 64'hF0);
    tick();
    chk("t1 bv k+2", {63'd0, s_bvalid}, 64'd0);
    chk("t1 bready", {62'd0, m_bready}, 64'd2);
    chk("t1 awv drop", {62'd0, m_awvalid}, 64'd0);
    tick();
    chk("t1 bv k+3", {63'd0, s_bvalid}, 64'd1);
    chk("t1 bresp", {62'd0, s_bresp}, 64'd0);
    chk("t1 bready drop", {62'd0, m_bready}, 64'd0);
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0;
    chk("t1 bv done", {63'd0, s_bvalid}, 64'd0);
    chk("t1 awready", {63'd0, s_awready}, 64'd1);

    // 2: W two cycles before AW, slow bready, slave 0 SLVERR
    m_bresp = 4'b0010;
    s_wdata = 32'h11223344; s_wstrb = 4'h3;
    s_wvalid = 1'b1;
    tick();
    s_wvalid = 1'b0;
    chk("t2 wready", {63'd0, s_wready}, 64'd0);
    chk("t2 awready", {63'd0, s_awready}, 64'd1);
    chk("t2 early", {62'd0, m_wvalid}, 64'd0);
    tick();
    s_awaddr = 8'h04; s_awvalid = 1'b1;
    tick();
    s_awvalid = 1'b0;
    chk("t2 awvalid", {62'd0, m_awvalid}, 64'd1);
    chk("t2 wvalid", {62'd0, m_wvalid}, 64'd1);
    chk("t2 awaddr", {48'd0, m_awaddr}, 64'h0004);
    chk("t2 wdata", m_wdata, 64'h11223344);
    chk("t2 wstrb", {56'd0, m_wstrb}, 64'h03);
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      chk("t2 bv hold", {63'd0, s_bvalid}, 64'd1);
      chk("t2 bresp", {62'd0, s_bresp}, 64'd2);
      if (i < 2) tick();
    end
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0;
    chk("t2 bv done", {63'd0, s_bvalid}, 64'd0);
    chk("t2 single", {62'd0, m_awvalid}, 64'd0);

    // 3: read 0x1C, slave 1 SLVERR, arready late
    m_rdata   = 64'hCAFEF00D_00000000;
    m_rresp   = 4'b1000;
    m_arready = 2'b00;
    s_araddr = 8'h1C; s_arvalid = 1'b1;
    tick();
    s_arvalid = 1'b0;
    chk("t3 arready", {63'd0, s_arready}, 64'd0);
    chk("t3 araddr", {48'd0, m_araddr}, 64'h1C00);
    cnt = m_arvalid == 2'b10 ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (m_arvalid == 2'b10) cnt++;
    end
    m_arready = 2'b11;
    tick();
    chk("t3 arv cycles", 64'(cnt), 64'd5);
    chk("t3 arv drop", {62'd0, m_arvalid}, 64'd0);
    chk("t3 rready", {62'd0, m_rready}, 64'd2);
    tick();
    chk("t3 rvalid", {63'd0, s_rvalid}, 64'd1);
    chk("t3 rdata", {32'd0, s_rdata}, 64'hCAFEF00D);
    chk("t3 rresp", {62'd0, s_rresp}, 64'd2);
    chk("t3 rready drop", {62'd0, m_rready}, 64'd0);
    s_rready = 1'b1;
    tick();
    s_rready = 1'b0;
    chk("t3 rv done", {63'd0, s_rvalid}, 64'd0);
    chk("t3 arready", {63'd0, s_arready}, 64'd1);

    // 4: unmapped write 0x24 and read 0xF0
    s_awaddr = 8'h24; s_awvalid = 1'b1;
    s_wdata = 32'h99999999; s_wstrb = 4'hF;
    s_wvalid = 1'b1;
    s_araddr = 8'hF0; s_arvalid = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    s_arvalid = 1'b0;
    chk("t4 bvalid", {63'd0, s_bvalid}, 64'd1);
    chk("t4 bresp", {62'd0, s_bresp}, 64'd3);
    chk("t4 rvalid", {63'd0, s_rvalid}, 64'd1);
    chk("t4 rresp", {62'd0, s_rresp}, 64'd3);
    chk("t4 rdata", {32'd0, s_rdata}, 64'd0);
    chk("t4 no fwd", {58'd0, m_awvalid, m_wvalid,
                      m_arvalid}, 64'd0);
    s_bready = 1'b1; s_rready = 1'b1;
    tick();
    s_bready = 1'b0; s_rready = 1'b0;
    chk_quiet("t4 done");

    // 5: concurrent write 0x00 and read 0x18
    m_bresp = 4'b1000;
    m_rresp = 4'b0010;
    m_rdata = 64'h55AA55AA_12345678;
    s_awaddr = 8'h00; s_awvalid = 1'b1;
    s_wdata = 32'h0BADCAFE; s_wstrb = 4'hF;
    s_wvalid = 1'b1;
    s_araddr = 8'h18; s_arvalid = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    s_arvalid = 1'b0;
    chk("t5 awvalid", {62'd0, m_awvalid}, 64'd1);
    chk("t5 arvalid", {62'd0, m_arvalid}, 64'd2);
    chk("t5 araddr", {48'd0, m_araddr}, 64'h1800);
    chk("t5 wdata", m_wdata, 64'h0BADCAFE);
    tick(); tick();
    chk("t5 bvalid", {63'd0, s_bvalid}, 64'd1);
    chk("t5 bresp", {62'd0, s_bresp}, 64'd0);
    chk("t5 rvalid", {63'd0, s_rvalid}, 64'd1);
    chk("t5 rdata", {32'd0, s_rdata}, 64'h55AA55AA);
    chk("t5 rresp", {62'd0, s_rresp}, 64'd0);
    s_bready = 1'b1; s_rready = 1'b1;
    tick();
    s_bready = 1'b0; s_rready = 1'b0;
    chk_quiet("t5 done");

    // 6: reset while waiting for the write response
    m_bresp  = 4'b0000;
    m_bvalid = 2'b00;
    s_awaddr = 8'h10; s_awvalid = 1'b1;
    s_wdata = 32'h77777777; s_wvalid = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    tick();
    chk("t6 bwait", {62'd0, m_bready}, 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6 async bready", {62'd0, m_bready}, 64'd0);
    chk("t6 async awaddr", {48'd0, m_awaddr}, 64'd0);
    chk("t6 async wdata", m_wdata, 64'd0);
    chk("t6 async rdy", {62'd0, s_awready, s_arready},
        64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_bvalid = 2'b11;
    tick();
    chk("t6 no stale", {63'd0, s_bvalid}, 64'd0);
    chk("t6 awready", {63'd0, s_awready}, 64'd1);
    s_awaddr = 8'h08; s_awvalid = 1'b1;
    s_wdata = 32'hA5A5A5A5; s_wvalid = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    chk("t6 awvalid", {62'd0, m_awvalid}, 64'd1);
    chk("t6 awaddr", {48'd0, m_awaddr}, 64'h0008);
    tick();
    chk("t6 bv k+2", {63'd0, s_bvalid}, 64'd0);
    tick();
    chk("t6 bv k+3", {63'd0, s_bvalid}, 64'd1);
    chk("t6 bresp", {62'd0, s_bresp}, 64'd0);
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0;
    chk("t6 bv done", {63'd0, s_bvalid}, 64'd0);

    $display("%0d/%0d checks passed",
             total - fails, total);
    $finish;
  end

endmodule
